// File: rtl/uart_frame_pkg.sv
// Shared constants and state encodings for the UART frame receiver.
package uart_frame_pkg;

    localparam int         FRAME_LEN        = 16;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {HUNT, LOAD, CSUM, COMMIT} asm_state_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP}  uart_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop RX synchroniser, mid-bit sampling and stop-bit check.
module uart_rx_byte
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic       byte_stb,
    output logic [7:0] byte_data,
    output logic       ferr
);

    localparam int                CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]     FULL = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shreg;
    logic          rx_p0, rx_p1, rx_p2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_p0    <= 1'b1;
            rx_p1    <= 1'b1;
            rx_p2    <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bitn     <= '0;
            byte_stb <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            // synchroniser stages; rx_p2 only serves falling-edge detection
            rx_p0    <= RX;
            rx_p1    <= rx_p0;
            rx_p2    <= rx_p1;
            byte_stb <= 1'b0;
            ferr     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_p1 && rx_p2) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (rx_p1) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            bitn  <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_p1, shreg[7:1]};
                        if (bitn == 3'd7) state <= STOP;
                        else              bitn  <= bitn + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_p1) begin
                            byte_stb  <= 1'b1;
                            byte_data <= shreg;
                        end else begin
                            ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler with double-buffered 16x8 pixel store and registered read port.
// Optional trailing XOR checksum byte enabled by defining UART_FRAME_RX_CHECKSUM_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         TIMEOUT_CLKS = 12000,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_ready,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       rx_active
);

    localparam int            TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS);

    logic          byte_stb;
    logic [7:0]    byte_data;
    logic          uart_ferr;
    asm_state_t    state;
    logic [3:0]    idx;
    logic [TW-1:0] tcnt;
    logic          bank_sel;
    logic          timeout;
    logic          store_we;
    logic [7:0]    store_mem [0:2*FRAME_LEN-1];
`ifdef UART_FRAME_RX_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .CLK       (CLK),
        .RST       (RST),
        .RX        (RX),
        .byte_stb  (byte_stb),
        .byte_data (byte_data),
        .ferr      (uart_ferr)
    );

    assign timeout   = (tcnt == TMAX);
    assign store_we  = (state == LOAD) && byte_stb;
    assign rx_active = (state != HUNT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= HUNT;
            idx         <= '0;
            tcnt        <= '0;
            bank_sel    <= 1'b0;
            frame_ready <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_ready <= 1'b0;
            frame_err   <= 1'b0;
            tcnt        <= (state == HUNT || byte_stb) ? '0 : tcnt + 1'b1;
            case (state)
                HUNT: begin
                    if (uart_ferr) frame_err <= 1'b1;
                    if (byte_stb && byte_data == HDR_BYTE) begin
                        idx   <= '0;
                        state <= LOAD;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (byte_stb) begin
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (idx == 4'(FRAME_LEN - 1)) begin
`ifdef UART_FRAME_RX_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= COMMIT;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (uart_ferr || timeout) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end
                end
`ifdef UART_FRAME_RX_CHECKSUM_EN
                CSUM: begin
                    if (byte_stb) begin
                        if (byte_data == csum) begin
                            state <= COMMIT;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end
                    end else if (uart_ferr || timeout) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end
                end
`endif
                COMMIT: begin
                    // new frame becomes the front bank atomically
                    if (uart_ferr) frame_err <= 1'b1;
                    bank_sel    <= ~bank_sel;
                    frame_ready <= 1'b1;
                    frame_valid <= 1'b1;
                    state       <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (store_we) store_mem[{~bank_sel, idx}] <= byte_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) rd_data <= '0;
        else     rd_data <= store_mem[{bank_sel, rd_addr}];
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx (8 clocks per bit, short timeout).
module tb_uart_frame_rx;

    localparam int CPB  = 8;
    localparam int TOUT = 200;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX  = 1'b1;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       frame_ready, frame_valid, frame_err, rx_active;

    int checks   = 0;
    int failures = 0;
    int nready   = 0;
    int nerr     = 0;
    int rd_at_ready = -1;
    int rd_after    = -1;
    bit cap_next    = 1'b0;

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TOUT), .HDR_BYTE(8'hA5)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX          (RX),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .rx_active   (rx_active)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (cap_next) begin
            rd_after = int'(rd_data);
            cap_next = 1'b0;
        end
        if (frame_ready) begin
            nready++;
            rd_at_ready = int'(rd_data);
            cap_next    = 1'b1;
        end
        if (frame_err) nerr++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(CPB);
        end
        RX = stop_bit;
        tick(CPB);
        RX = 1'b1;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] step);
        logic [7:0] v;
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = base + step * 8'(i);
            x = x ^ v;
            send_byte(v, 1'b1);
        end
`ifdef UART_FRAME_RX_CHECKSUM_EN
        send_byte(x, 1'b1);
`endif
        tick(4);
    endtask

    task automatic read_at(input logic [3:0] a, output int d);
        rd_addr = a;
        tick(2);
        d = int'(rd_data);
    endtask

    initial begin
        int d;
        tick(3);
        RST = 1'b0;
        tick(1);
        check("reset_rd_data",     int'(rd_data),     0);
        check("reset_frame_ready", int'(frame_ready), 0);
        check("reset_frame_valid", int'(frame_valid), 0);
        check("reset_frame_err",   int'(frame_err),   0);
        check("reset_rx_active",   int'(rx_active),   0);

        // basic frame 00..0F
        send_frame(8'h00, 8'h01);
        check("basic_nready", nready, 1);
        check("basic_valid",  int'(frame_valid), 1);
        check("basic_nerr",   nerr, 0);
        rd_addr = 4'd0;
        tick(2);
        rd_addr = 4'd3;
        tick(1);
        check("basic_rd3_latency", int'(rd_data), 8'h03);
        read_at(4'd15, d); check("basic_rd15", d, 8'h0F);
        read_at(4'd0,  d); check("basic_rd0",  d, 8'h00);

        // bank atomicity: 55 frame committed, then AA streamed with rd_addr held at 0
        send_frame(8'h55, 8'h00);
        check("atom_nready1", nready, 2);
        rd_addr = 4'd0;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'hAA, 1'b1);
        check("atom_mid_old", int'(rd_data), 8'h55);
        for (int i = 0; i < 8; i++) send_byte(8'hAA, 1'b1);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        tick(4);
        check("atom_nready2",     nready, 3);
        check("atom_at_ready",    rd_at_ready, 8'h55);
        check("atom_after_ready", rd_after, 8'hAA);

        // hunt ignores noise; A5 inside the frame is data
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("hunt_idle", int'(rx_active), 0);
        send_frame(8'hA5, 8'h00);
        check("hunt_nready", nready, 4);
        check("hunt_nerr",   nerr, 0);
        read_at(4'd0,  d); check("hunt_rd0",  d, 8'hA5);
        read_at(4'd7,  d); check("hunt_rd7",  d, 8'hA5);
        read_at(4'd15, d); check("hunt_rd15", d, 8'hA5);

        // timeout after partial frame
        rd_addr = 4'd0;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 7; i++) send_byte(8'h11 + 8'(i), 1'b1);
        check("tout_active", int'(rx_active), 1);
        tick(TOUT + 20);
        check("tout_nerr",   nerr, 1);
        check("tout_idle",   int'(rx_active), 0);
        check("tout_nready", nready, 4);
        read_at(4'd0, d); check("tout_bank_kept", d, 8'hA5);

        // framing error while hunting
        send_byte(8'h3C, 1'b0);
        tick(4);
        check("ferr_hunt_nerr", nerr, 2);
        check("ferr_hunt_idle", int'(rx_active), 0);

        // framing error mid-frame aborts, next frame accepted
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b1);
        send_byte(8'h5A, 1'b0);
        tick(4);
        check("ferr_load_nerr",   nerr, 3);
        check("ferr_load_idle",   int'(rx_active), 0);
        check("ferr_load_nready", nready, 4);
        send_frame(8'h20, 8'h01);
        check("ferr_next_nready", nready, 5);
        read_at(4'd5, d); check("ferr_next_rd5", d, 8'h25);

`ifdef UART_FRAME_RX_CHECKSUM_EN
        // XOR of 01..10 is 10
        send_byte(8'hA5, 1'b1);
        for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h10, 1'b1);
        tick(4);
        check("csum_ok_nready", nready, 6);
        read_at(4'd0, d); check("csum_ok_rd0", d, 8'h01);
        send_byte(8'hA5, 1'b1);
        for (int i = 1; i <= 16; i++) send_byte(8'(i) + 8'h40, 1'b1);
        send_byte(8'h11, 1'b1);
        tick(4);
        check("csum_bad_nerr",   nerr, 4);
        check("csum_bad_nready", nready, 6);
        read_at(4'd0, d); check("csum_bad_rd0", d, 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
